jk_seq_driver: RTL
==================

# jk_seq_driver

Serial excitation driver for a downstream JK flip-flop: accepts a WIDTH-bit target pattern over a valid/ready handshake and drives `j`/`k` one bit per cycle, LSB first, so the driven flop's `q` reproduces the pattern. It sits in front of the team's JK flop and closes the loop through `q_fb`, the flop's `q`. It compares each produced bit against the target and raises a sticky error on mismatch.

## Interface
- `WIDTH`, 8: pattern length in bits, ≥2.
- `USE_TOGGLE`, 0: 0 uses set/reset excitation (10/01); 1 uses toggle (11) for every changing bit.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load_valid` in 1: pattern offered.
- `load_ready` out 1: combinational, 1 iff state is IDLE.
- `pattern` in WIDTH: target bits; bit 0 is produced first.
- `q_fb` in 1: `q` of the driven JK flop.
- `j`, `k` out 1 each: registered excitation to the driven flop.
- `busy` out 1: registered, high from the accept edge until the done edge.
- `done` out 1: registered, one-cycle pulse after the final check.
- `err` out 1: registered, sticky mismatch flag.
- `err_clr` in 1: synchronous clear of `err`.

## Operation
- Reset state: IDLE. `j`=0, `k`=0, `busy`=0, `done`=0, `err`=0, `q_model`=0, shift register=0, check pipeline invalid. `load_ready`=1.
- States:
  - IDLE → RUN on `load_valid && load_ready`.
  - RUN lasts exactly WIDTH cycles, then → CHECK.
  - CHECK lasts 1 cycle, then → IDLE.
- IDLE: `q_model <= q_fb` every cycle, which resyncs to the real flop. `j`=`k`=0.
- Excitation from `q_model` to target bit t, `USE_TOGGLE`=0:
  - 0→0: 00.
  - 0→1: 10.
  - 1→0: 01.
  - 1→1: 00.
- With `USE_TOGGLE`=1: bit unchanged → 00; bit changes → 11.
- Each drive edge updates `q_model <= t` and shifts the pattern right by one.
- Check pipeline: register `exp` <= t and `exp_v` <= 1 at each drive edge. Register `exp2` <= `exp` and `exp2_v` <= `exp_v`. This accounts for one cycle of flop capture plus one cycle of feedback.
- Error rule: at any edge with `exp2_v` set and `q_fb != exp2`, `err <= 1`.
- `err_clr` clears `err`; a simultaneous new mismatch wins and `err` stays 1.
- `load_valid` while busy is ignored (no accept) and `pattern` is not sampled.
- Asynchronous reset mid-operation: all state returns to reset values immediately. The partial pattern is abandoned and no `done` is produced.

## Timing
- E0 = accept edge:
  - `pattern` is captured.
  - `j`/`k` for bit 0 are registered from the `q_model` value at E0.
  - `busy` <= 1.
- Bit i is on `j`/`k` during cycle i, i.e. E_i..E_{i+1}, for i=0..WIDTH-1.
- The driven flop captures bit i at E_{i+1}. `q_fb` shows bit i in cycle i+1 and is checked at E_{i+2}.
- Checks occur at edges E2..E(WIDTH+1).
- E(WIDTH): enter CHECK; `j`=`k`=0.
- E(WIDTH+1):
  - last check;
  - state → IDLE;
  - `busy` <= 0;
  - `done` <= 1 for exactly one cycle.
- Accept-to-done latency: WIDTH+1 cycles.
- Earliest next accept is E(WIDTH+2), because `load_ready` is high in cycle WIDTH+1.
- Throughput: one pattern per WIDTH+2 cycles.

## Test plan
- Reset: hold `rst`=0 with random inputs → `j`=`k`=`busy`=`done`=`err`=0 and `load_ready`=1. Release reset → nothing changes until `load_valid`.
- Set/reset mode: WIDTH=8, `USE_TOGGLE`=0, `pattern`=8'b1011_0010, `q_fb` from a JK flop model reset to 0.
  - `jk` per cycle: 00, 10, 01, 00, 10, 00, 01, 10.
  - `done` pulses at E9; `err`=0.
- Toggle mode: same stimulus with `USE_TOGGLE`=1.
  - `jk` per cycle: 00, 11, 11, 00, 11, 00, 11, 11.
  - `q_fb` sequence matches the pattern; `err`=0.
- Fault and clear: `q_fb` forced to 0, `pattern`=8'h01.
  - `err` rises at E2 and stays high through `done`.
  - `err_clr` pulse → `err`=0 next cycle.
  - `err_clr` coincident with a new mismatch → `err` stays 1.
- Handshake and resync:
  - `load_valid` held high throughout: second accept occurs at E10, not earlier.
  - With `q_fb`=1 in IDLE and `pattern`=8'h00: first `jk`=01, remaining `jk`=00.
- Reset mid-RUN: assert `rst`=0 during cycle 4.
  - `j`=`k`=0 and `busy`=0 immediately, without waiting for a clock.
  - No `done` pulse; `err`=0.
  - After release, a fresh load completes normally.

Source files
------------

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: serialises a WIDTH-bit target pattern onto the j/k inputs of a
// downstream JK flop, LSB first, and checks the flop's q (q_fb) against the
// target two edges later. Mismatches set a sticky err flag.
module jk_seq_driver #(
  parameter int WIDTH      = 8,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             q_model;
  logic             exp_b, exp_v;
  logic             exp2, exp2_v;

  logic             t_bit;
  logic             drive;
  logic             j_nx, k_nx;
  logic             mismatch;

  assign load_ready = (state == IDLE);

  // Next target bit, whether this edge drives a bit, and its excitation.
  always_comb begin
    t_bit = shreg[0];
    drive = 1'b0;
    if (state == IDLE) begin
      t_bit = pattern[0];
      drive = load_valid;
    end else if (state == RUN) begin
      drive = (cnt != CW'(WIDTH));
    end
    if (USE_TOGGLE) begin
      j_nx = (q_model != t_bit);
      k_nx = (q_model != t_bit);
    end else begin
      j_nx = ~q_model & t_bit;
      k_nx = q_model & ~t_bit;
    end
    mismatch = exp2_v && (q_fb != exp2);
  end

  // Sequencer, excitation outputs and the two-stage check pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      q_model <= 1'b0;
      exp_b   <= 1'b0;
      exp_v   <= 1'b0;
      exp2    <= 1'b0;
      exp2_v  <= 1'b0;
      j       <= 1'b0;
      k       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // exp2 lines up with q_fb: one edge for flop capture, one for feedback
      exp2   <= exp_b;
      exp2_v <= exp_v;
      // a new mismatch beats a simultaneous clear
      if (mismatch)     err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      done  <= 1'b0;
      j     <= 1'b0;
      k     <= 1'b0;
      exp_v <= 1'b0;
      if (drive) begin
        j       <= j_nx;
        k       <= k_nx;
        q_model <= t_bit;
        exp_b   <= t_bit;
        exp_v   <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= pattern >> 1;
            cnt   <= CW'(1);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            // track the real flop so the first bit excites from its true q
            q_model <= q_fb;
          end
        end
        RUN: begin
          if (cnt == CW'(WIDTH)) begin
            state <= CHECK;
          end else begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
